// File: rtl/mac_seq_if.sv
// Handshake, operand-memory and MAC-drive bundle for the MAC job sequencer.
// The requester/environment side is master; the sequencer is slave.
interface mac_seq_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
);
  logic              start;
  logic              mode;
  logic [LEN_W-1:0]  len;
  logic [7:0]        bias;
  logic [7:0]        x_val;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data_a;
  logic [7:0]        mem_data_b;
  logic [7:0]        mac_in_1;
  logic [7:0]        mac_in_2;
  logic [7:0]        mac_in_add;
  logic              mac_mul_sel;
  logic              mac_add_sel;
  logic [16:0]       mac_result;
  logic              busy;
  logic              done;
  logic [16:0]       result;

  modport master (
    output start, mode, len, bias, x_val, mem_data_a, mem_data_b, mac_result,
    input  mem_rd, mem_addr, mac_in_1, mac_in_2, mac_in_add, mac_mul_sel,
           mac_add_sel, busy, done, result
  );

  modport slave (
    input  start, mode, len, bias, x_val, mem_data_a, mem_data_b, mac_result,
    output mem_rd, mem_addr, mac_in_1, mac_in_2, mac_in_add, mac_mul_sel,
           mac_add_sel, busy, done, result
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the two-stage 8x8 MAC: fetches operands, issues every other
// cycle to respect the 2-cycle feedback latency, captures the 17-bit result.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | mem_rd strobe, MAC sees zeros (bubble slot)
// ISSUE  | operands from memory drive the MAC
// DRAIN1 | last issue in stage 1
// DRAIN2 | last result on mac_result, captured at this edge
// DONE   | done pulse, result valid
module mac_seq_ctrl #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input logic     clk,
  input logic     reset,
  mac_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_DRAIN1, S_DRAIN2, S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t            state;
  logic              mode_q;
  logic [LEN_W-1:0]  len_q;
  logic [7:0]        bias_q;
  logic [7:0]        x_q;
  logic [LEN_W-1:0]  idx;
  logic              busy_q;
  logic              done_q;
  logic [16:0]       result_q;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [7:0] in_1, in_2, in_add;
  logic       mul_sel, add_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mode_q     <= 1'b0;
      len_q      <= '0;
      bias_q     <= '0;
      x_q        <= '0;
      idx        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.len != '0) begin
              mode_q     <= bus.mode;
              len_q      <= bus.len;
              bias_q     <= bus.bias;
              x_q        <= bus.x_val;
              idx        <= '0;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= '0;
              state      <= S_FETCH;
            end else begin
              result_q <= bus.mode ? 17'd0 : {9'b0, bus.bias};
              done_q   <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          mem_rd_q <= 1'b0;
          state    <= S_ISSUE;
        end
        S_ISSUE: begin
          idx <= idx + ONE;
          if (idx == len_q - ONE) begin
            state <= S_DRAIN1;
          end else begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= ADDR_W'(idx + ONE);
            state      <= S_FETCH;
          end
        end
        S_DRAIN1: state <= S_DRAIN2;
        S_DRAIN2: begin
          result_q <= bus.mac_result;
          done_q   <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Only ISSUE drives the MAC; every other slot feeds zeros so the
  // interleaved odd-slot pipeline chain stays at zero.
  always_comb begin
    in_1    = '0;
    in_2    = '0;
    in_add  = '0;
    mul_sel = 1'b0;
    add_sel = 1'b0;
    if (state == S_ISSUE) begin
      if (!mode_q) begin
        in_1 = bus.mem_data_a;
        in_2 = bus.mem_data_b;
        if (idx == '0) in_add = bias_q;
        else           add_sel = 1'b1;
      end else if (idx == '0) begin
        in_1 = bus.mem_data_a;
        in_2 = 8'd1;
      end else begin
        in_2    = x_q;
        in_add  = bus.mem_data_a;
        mul_sel = 1'b1;
      end
    end
  end

  assign bus.mac_in_1    = in_1;
  assign bus.mac_in_2    = in_2;
  assign bus.mac_in_add  = in_add;
  assign bus.mac_mul_sel = mul_sel;
  assign bus.mac_add_sel = add_sel;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: models the operand memory and the two-stage MAC,
// checks timing and results against a plain-arithmetic job model.
module tb_mac_seq_ctrl;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  mac_seq_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  mac_seq_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.mem_data_a <= mem_a[bus.mem_addr];
      bus.mem_data_b <= mem_b[bus.mem_addr];
    end
  end

  // MAC datapath: stage 1 registers product and addend, stage 2 the sum.
  logic [15:0] s1_prod;
  logic [16:0] s1_add;
  logic [16:0] mac_out;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_prod <= '0;
      s1_add  <= '0;
      mac_out <= '0;
    end else begin
      s1_prod <= bus.mac_mul_sel ? 16'(mac_out[15:0] * bus.mac_in_2)
                                 : 16'(bus.mac_in_1 * bus.mac_in_2);
      s1_add  <= bus.mac_add_sel ? mac_out : {9'b0, bus.mac_in_add};
      mac_out <= 17'(s1_prod + s1_add);
    end
  end
  assign bus.mac_result = mac_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [16:0] ref_result(input logic md, input int n, input logic [7:0] b,
                                             input logic [7:0] xv);
    int unsigned acc;
    if (!md) begin
      acc = b;
      for (int i = 0; i < n; i++) acc += mem_a[i] * mem_b[i];
    end else begin
      if (n == 0) return 17'd0;
      acc = mem_a[0];
      for (int i = 1; i < n; i++) acc = ((acc * xv) % 65536 + mem_a[i]) % 131072;
    end
    return 17'(acc % 131072);
  endfunction

  // inject: 0 none, 1 extra start in cycle 3, 2 reset in cycle 4
  task automatic run_job(input logic md, input int n, input logic [7:0] b,
                         input logic [7:0] xv, input int inject);
    logic [16:0] exp_r;
    int cyc, n_rd, done_cyc;
    exp_r = ref_result(md, n, b, xv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = md;
    bus.len   = LEN_W'(n);
    bus.bias  = b;
    bus.x_val = xv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = 1'($urandom);
    bus.len   = LEN_W'($urandom);
    bus.bias  = 8'($urandom);
    bus.x_val = 8'($urandom);
    cyc = 1;
    n_rd = 0;
    done_cyc = 0;
    while (cyc <= 2 * n + 8) begin
      if (inject == 2 && cyc == 4) begin
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_done", 32'(bus.done), 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (inject == 1 && cyc == 3) begin
        bus.start = 1'b1;
        bus.mode  = ~md;
        bus.len   = LEN_W'(2);
        bus.bias  = ~b;
      end
      if (inject == 1 && cyc == 4) bus.start = 1'b0;
      chk("busy", 32'(bus.busy), 1);
      if (bus.mem_rd) begin
        chk("rd_addr", 32'(bus.mem_addr), 32'(n_rd));
        chk("rd_cycle", 32'(cyc), 32'(2 * n_rd + 1));
        n_rd++;
      end
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_cycle", 32'(done_cyc), (n == 0) ? 32'd1 : 32'(2 * n + 3));
    chk("n_reads", 32'(n_rd), 32'(n));
    chk("result", 32'(bus.result), 32'(exp_r));
    @(negedge clk);
    chk("done_low", 32'(bus.done), 0);
    chk("busy_low", 32'(bus.busy), 0);
    chk("result_held", 32'(bus.result), 32'(exp_r));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.len   = '0;
    bus.bias  = '0;
    bus.x_val = '0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_result", 32'(bus.result), 0);
    chk("reset_mem_rd", 32'(bus.mem_rd), 0);
    chk("reset_mem_addr", 32'(bus.mem_addr), 0);
    chk("reset_mac_drive", {bus.mac_in_1, bus.mac_in_2, bus.mac_in_add, 6'b0,
                            bus.mac_mul_sel, bus.mac_add_sel}, 0);
    reset = 1'b0;

    mem_a[0] = 8'd1; mem_b[0] = 8'd2;
    mem_a[1] = 8'd3; mem_b[1] = 8'd4;
    mem_a[2] = 8'd5; mem_b[2] = 8'd6;
    run_job(1'b0, 3, 8'd7, 8'd0, 0);
    chk("tp_dot51", 32'(bus.result), 51);

    mem_a[0] = 8'd1; mem_a[1] = 8'd2; mem_a[2] = 8'd3;
    run_job(1'b1, 3, 8'd0, 8'd2, 0);
    chk("tp_horner11", 32'(bus.result), 11);

    mem_a[0] = 8'd200;
    run_job(1'b1, 1, 8'd0, 8'd5, 0);
    chk("tp_horner200", 32'(bus.result), 200);

    run_job(1'b0, 0, 8'd9, 8'd0, 0);
    chk("tp_len0", 32'(bus.result), 9);
    run_job(1'b1, 0, 8'd9, 8'd3, 0);

    for (int i = 0; i < 3; i++) begin
      mem_a[i] = 8'd255;
      mem_b[i] = 8'd255;
    end
    run_job(1'b0, 3, 8'd0, 8'd0, 0);
    chk("tp_wrap", 32'(bus.result), 64003);

    mem_a[0] = 8'd1; mem_b[0] = 8'd2;
    mem_a[1] = 8'd3; mem_b[1] = 8'd4;
    mem_a[2] = 8'd5; mem_b[2] = 8'd6;
    run_job(1'b0, 3, 8'd7, 8'd0, 1);
    chk("tp_restart_ignored", 32'(bus.result), 51);

    run_job(1'b0, 3, 8'd7, 8'd0, 2);
    mem_a[0] = 8'd1; mem_b[0] = 8'd1;
    run_job(1'b0, 1, 8'd0, 8'd0, 0);
    chk("tp_after_reset", 32'(bus.result), 1);

    for (int j = 0; j < 40; j++) begin
      int n;
      for (int i = 0; i < 256; i++) begin
        mem_a[i] = 8'($urandom);
        mem_b[i] = 8'($urandom);
      end
      n = (j % 8 == 7) ? int'($urandom_range(20, 40)) : int'($urandom_range(0, 8));
      run_job(1'($urandom), n, 8'($urandom), 8'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
